pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
Parametrised N-stage pipeline register chain with per-stage valid bits, stall/flush control and debug stepping. It generalises the fixed IF_ID/ID_EX/EX_M/M_WB registers into one reusable block.
- Stall propagates upstream; bubbles are inserted downstream of a stall.
- Flush clears a stage.
- A debug-unit clock enable, plus single-step, gates all advancement.
- Intended for the next-generation core top and for widened multi-issue experiments.

Parameters:
NB_DATA, 32, payload width per stage
N_STAGES, 4, number of register stages (>=2)
NB_CNT, 32, width of performance counters

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous reset, active-low
i_dunit_clk_en  in  1  debug-unit run enable; 1 = free-running
i_step  in  1  single-step request, used when i_dunit_clk_en=0
i_data  in  NB_DATA  payload into stage 0
i_valid  in  1  payload valid into stage 0
i_stall  in  N_STAGES  bit k: stage k must hold its contents
i_flush  in  N_STAGES  bit k: stage k loads a bubble
o_ready  out  1  stage 0 accepts i_data this cycle
o_data  out  N_STAGES*NB_DATA  stage k contents at bits [k*NB_DATA +: NB_DATA]
o_valid  out  N_STAGES  stage k valid
o_retired_cnt  out  NB_CNT  valid items leaving the last stage
o_stall_cnt  out  NB_CNT  advance cycles with stage 0 held
o_bubble_cnt  out  NB_CNT  bubbles inserted by stall

Behaviour:
- Reset (i_reset=0, async): all data regs 0, all valid 0, step edge register 0, counters 0. Outputs follow immediately.
- Step edge detect: step_q <= i_step each cycle; step_pulse = i_step & ~step_q.
- adv = i_dunit_clk_en | step_pulse. When adv=0 all stage regs and counters hold.
- A held-high i_step produces exactly one advance.
- Step is ignored (no extra advance) while i_dunit_clk_en=1.
- Hold vector, combinational: h[N-1] = i_stall[N-1]; h[k] = i_stall[k] | h[k+1].
- o_ready = adv & ~h[0] & ~i_flush[0].
- Per-stage update on a clock edge with adv=1, evaluated in priority order:
  1. i_flush[k] → data 0, valid 0 (flush beats stall).
  2. h[k] → hold data and valid.
  3. k>0 and h[k-1] → bubble: data 0, valid 0.
  4. k=0 → data i_data, valid i_valid.
  5. Otherwise, k>0 → data/valid copied from stage k-1.
- Latency: item accepted at edge t appears in stage k after edge t+k (k+1 advancing edges total) with no stalls/flushes.
- Invalid items (i_valid=0) still move, as bubbles.
- Data of an invalid stage is don't-care for consumers, but must be 0 after flush, bubble or reset.
- Simultaneous stall at several stages: the most downstream stalled stage defines the bubble point. The hold chain naturally covers all stages upstream of it.
- Flush of a held stage clears it. Upstream stages remain held.
- o_data and o_valid are registered outputs, not combinational from i_data.

Optional Feature:
PIPE_STAGE_PERF_EN
- Defined: counters active, updating only on adv=1 edges:
  - o_retired_cnt +1 when o_valid[N-1]=1 and ~h[N-1] and ~i_flush[N-1].
  - o_stall_cnt +1 when h[0]=1.
  - o_bubble_cnt +1 per stage k>0 that took the bubble branch (may add >1 per cycle).
  - All counters wrap modulo 2^NB_CNT.
- Undefined: counter outputs tied to 0, no counter flops.

Test Plan (N_STAGES=4, NB_DATA=8):
- Reset: deassert i_reset after 3 cycles → o_valid=4'b0000, o_data=0, o_ready=1 with i_dunit_clk_en=1.
- Stream: push 0x11,0x22,0x33,0x44, all valid, no stall → after 4th edge o_data = {0x11,0x22,0x33,0x44} (stage3..stage0), o_valid=4'b1111. Next edge with i_valid=0 → o_retired_cnt=1 (PERF_EN).
- Stall: with a full pipe, i_stall=4'b0010 for one cycle → stages 0,1 hold 0x44,0x33; stage2 becomes bubble (valid 0, data 0); stage3=0x22; o_ready=0; o_bubble_cnt=1.
- Flush over stall: i_stall[0]=1 and i_flush[0]=1 together → stage0 valid 0, data 0; stage1 unaffected if not held.
- Step: i_dunit_clk_en=0, i_step high for 3 cycles → exactly one advance. i_step low then high again → one more advance. Counters change only on those edges.
- Reset mid-stream: assert i_reset asynchronously between edges with valid=4'b1111 → o_valid=0 and counters=0 before the next edge.

Source files
------------

// File: rtl/pipe_stage_chain_if.sv
// Pipeline chain bus: stage-0 handshake, per-stage stall/flush controls,
// and the registered stage contents / valid bits.
//   master : the driver of the chain (core control, testbench)
//   slave  : pipe_stage_chain
// Signals:
//   i_data/i_valid   payload into stage 0
//   i_stall/i_flush  per-stage hold / bubble-load requests
//   o_ready          stage 0 accepts i_data this cycle
//   o_data/o_valid   stage k contents at [k*NB_DATA +: NB_DATA], valid bit k
interface pipe_stage_chain_if #(
  parameter int NB_DATA  = 32,
  parameter int N_STAGES = 4
);
  logic [NB_DATA-1:0]          i_data;
  logic                        i_valid;
  logic [N_STAGES-1:0]         i_stall;
  logic [N_STAGES-1:0]         i_flush;
  logic                        o_ready;
  logic [N_STAGES*NB_DATA-1:0] o_data;
  logic [N_STAGES-1:0]         o_valid;

  modport master (
    output i_data, i_valid, i_stall, i_flush,
    input  o_ready, o_data, o_valid
  );

  modport slave (
    input  i_data, i_valid, i_stall, i_flush,
    output o_ready, o_data, o_valid
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// N-stage pipeline register chain with per-stage valid bits, stall/flush
// control and debug-unit stepping.
// Optional build macro: PIPE_STAGE_PERF_EN enables the performance counters;
// without it the counter outputs are tied to zero and no counter flops exist.
// Ports:
//   i_clk, i_reset          clock, asynchronous active-low reset
//   i_dunit_clk_en          1 = free-running advance
//   i_step                  single-step request (rising edge) when halted
//   bus                     pipe_stage_chain_if slave (data/valid/stall/flush/ready)
//   o_retired_cnt           valid items leaving the last stage
//   o_stall_cnt             advance cycles with stage 0 held
//   o_bubble_cnt            bubbles inserted below a stall

// One register stage. Update priority: flush, hold, bubble, load.
module pipe_stage_cell #(
  parameter int NB_DATA = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               adv,
  input  logic               flush,
  input  logic               hold,
  input  logic               bubble,
  input  logic [NB_DATA-1:0] d_in,
  input  logic               v_in,
  output logic [NB_DATA-1:0] q,
  output logic               v
);
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      q <= '0;
      v <= 1'b0;
    end else if (adv) begin
      if (flush || (!hold && bubble)) begin
        q <= '0;
        v <= 1'b0;
      end else if (!hold) begin
        q <= d_in;
        v <= v_in;
      end
    end
  end
endmodule

module pipe_stage_chain #(
  parameter int NB_DATA  = 32,
  parameter int N_STAGES = 4,
  parameter int NB_CNT   = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_dunit_clk_en,
  input  logic              i_step,
  pipe_stage_chain_if.slave bus,
  output logic [NB_CNT-1:0] o_retired_cnt,
  output logic [NB_CNT-1:0] o_stall_cnt,
  output logic [NB_CNT-1:0] o_bubble_cnt
);
  logic                               step_q, step_pulse, adv;
  logic [N_STAGES-1:0]                h;
  logic [N_STAGES-1:0]                vld_pipe;
  logic [N_STAGES-1:0][NB_DATA-1:0]   stage_q;

  // Step edge detect runs every cycle so a held step yields one advance.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) step_q <= 1'b0;
    else          step_q <= i_step;
  end

  assign step_pulse = i_step & ~step_q;
  assign adv        = i_dunit_clk_en | step_pulse;

  // A stalled stage holds everything upstream of it.
  always_comb begin
    h = '0;
    h[N_STAGES-1] = bus.i_stall[N_STAGES-1];
    for (int k = N_STAGES-2; k >= 0; k--) h[k] = bus.i_stall[k] | h[k+1];
  end

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    logic [NB_DATA-1:0] d_in;
    logic               v_in, bub;
    if (k == 0) begin : g_head
      assign d_in = bus.i_data;
      assign v_in = bus.i_valid;
      assign bub  = 1'b0;
    end else begin : g_body
      assign d_in = stage_q[k-1];
      assign v_in = vld_pipe[k-1];
      assign bub  = h[k-1];
    end
    pipe_stage_cell #(.NB_DATA(NB_DATA)) u_cell (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .adv    (adv),
      .flush  (bus.i_flush[k]),
      .hold   (h[k]),
      .bubble (bub),
      .d_in   (d_in),
      .v_in   (v_in),
      .q      (stage_q[k]),
      .v      (vld_pipe[k])
    );
  end

  assign bus.o_ready = adv & ~h[0] & ~bus.i_flush[0];
  assign bus.o_data  = stage_q;
  assign bus.o_valid = vld_pipe;

`ifdef PIPE_STAGE_PERF_EN
  logic [NB_CNT-1:0] bub_inc;

  // Stages that take the bubble branch (not flushed, not held, upstream held).
  always_comb begin
    bub_inc = '0;
    for (int k = 1; k < N_STAGES; k++)
      bub_inc = bub_inc + NB_CNT'(~bus.i_flush[k] & ~h[k] & h[k-1]);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_retired_cnt <= '0;
      o_stall_cnt   <= '0;
      o_bubble_cnt  <= '0;
    end else if (adv) begin
      if (vld_pipe[N_STAGES-1] & ~h[N_STAGES-1] & ~bus.i_flush[N_STAGES-1])
        o_retired_cnt <= o_retired_cnt + NB_CNT'(1);
      if (h[0])
        o_stall_cnt <= o_stall_cnt + NB_CNT'(1);
      o_bubble_cnt <= o_bubble_cnt + bub_inc;
    end
  end
`else
  assign o_retired_cnt = '0;
  assign o_stall_cnt   = '0;
  assign o_bubble_cnt  = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
module tb_pipe_stage_chain;
  localparam int NB_DATA  = 8;
  localparam int N_STAGES = 4;
  localparam int NB_CNT   = 32;
  localparam int N_VEC    = 19;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b0;
  logic              en = 1'b1;
  logic              step = 1'b0;
  logic [NB_CNT-1:0] ret_cnt, stall_cnt, bub_cnt;

  pipe_stage_chain_if #(.NB_DATA(NB_DATA), .N_STAGES(N_STAGES)) bus ();

  pipe_stage_chain #(.NB_DATA(NB_DATA), .N_STAGES(N_STAGES), .NB_CNT(NB_CNT)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_dunit_clk_en(en),
    .i_step        (step),
    .bus           (bus),
    .o_retired_cnt (ret_cnt),
    .o_stall_cnt   (stall_cnt),
    .o_bubble_cnt  (bub_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       vld;
    logic [7:0] d;
    logic [3:0] stall;
    logic [3:0] flush;
    logic       en;
    logic       step;
    logic       rdy;
    logic [3:0] ev;
    logic [31:0] ed;
    int         r, s, b;
    logic       ret_v;
    logic [7:0] ret_d;
  } vec_t;

  vec_t       tbl[N_VEC];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sb_q[$];
  logic [7:0] sb_exp;
  logic       step_prev;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Independent view of the step edge, used to know when the chain advances.
  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) step_prev <= 1'b0;
    else          step_prev <= step;
  end

  // Retirement scoreboard: an item leaving stage 3 must match the queue head.
  always @(posedge i_clk) begin
    if (i_reset && (en || (step && !step_prev)) && bus.o_valid[3] &&
        !bus.i_stall[3] && !bus.i_flush[3]) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_retire: got %h with empty expected queue", bus.o_data[31:24]);
      end else begin
        sb_exp = sb_q.pop_front();
        if (bus.o_data[31:24] !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_retire: got %h expected %h", bus.o_data[31:24], sb_exp);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] st,
                       input logic [3:0] fl, input logic e, input logic s);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_stall = st;
    bus.i_flush = fl;
    en   = e;
    step = s;
  endtask

  initial begin
    //          vld d      stall    flush    en   step rdy  ev       ed            r s b ret  ret_d
    tbl[0]  = '{1, 8'h11, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0001, 32'h00000011, 0,0,0, 1'b0, 8'h00};
    tbl[1]  = '{1, 8'h22, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0011, 32'h00001122, 0,0,0, 1'b0, 8'h00};
    tbl[2]  = '{1, 8'h33, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0111, 32'h00112233, 0,0,0, 1'b0, 8'h00};
    tbl[3]  = '{1, 8'h44, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b1111, 32'h11223344, 0,0,0, 1'b0, 8'h00};
    tbl[4]  = '{0, 8'h00, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b1110, 32'h22334400, 1,0,0, 1'b1, 8'h11};
    tbl[5]  = '{1, 8'h55, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b1101, 32'h33440055, 2,0,0, 1'b1, 8'h22};
    tbl[6]  = '{1, 8'h66, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b1001, 32'h44000055, 3,1,1, 1'b1, 8'h33};
    tbl[7]  = '{1, 8'h77, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h00000000, 4,2,2, 1'b1, 8'h44};
    tbl[8]  = '{1, 8'h88, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0001, 32'h00000088, 4,2,2, 1'b0, 8'h00};
    tbl[9]  = '{1, 8'h99, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0011, 32'h00008899, 4,2,2, 1'b0, 8'h00};
    tbl[10] = '{1, 8'haa, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0101, 32'h008800aa, 4,2,2, 1'b0, 8'h00};
    tbl[11] = '{1, 8'hbb, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b1011, 32'h8800aabb, 4,2,2, 1'b0, 8'h00};
    tbl[12] = '{1, 8'hcc, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1011, 32'h8800aabb, 4,2,2, 1'b0, 8'h00};
    tbl[13] = '{1, 8'hcc, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1011, 32'h8800aabb, 4,2,2, 1'b0, 8'h00};
    tbl[14] = '{1, 8'hdd, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1011, 32'h8800aabb, 4,2,2, 1'b0, 8'h00};
    tbl[15] = '{1, 8'hdd, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0111, 32'h00aabbdd, 5,2,2, 1'b1, 8'h88};
    tbl[16] = '{0, 8'h00, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b1110, 32'haabbdd00, 5,2,2, 1'b0, 8'h00};
    tbl[17] = '{1, 8'hee, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b1101, 32'hbbdd00ee, 6,2,2, 1'b1, 8'haa};
    tbl[18] = '{1, 8'hff, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1101, 32'hbbdd00ee, 6,3,2, 1'b0, 8'h00};

    // Reset held for 3 cycles, then released between edges.
    drive(1'b0, 8'h00, 4'b0000, 4'b0000, 1'b1, 1'b0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    chk("reset_valid", 32'(bus.o_valid), 32'h0);
    chk("reset_data", bus.o_data, 32'h0);
    chk("reset_ready", 32'(bus.o_ready), 32'h1);
    chk("reset_retired", ret_cnt, 32'h0);
    chk("reset_bubble", bub_cnt, 32'h0);
    @(posedge i_clk);
    #1;

    for (int i = 0; i < N_VEC; i++) begin
      drive(tbl[i].vld, tbl[i].d, tbl[i].stall, tbl[i].flush, tbl[i].en, tbl[i].step);
      if (tbl[i].ret_v) sb_q.push_back(tbl[i].ret_d);
      @(negedge i_clk);
      chk($sformatf("row%0d_ready", i), 32'(bus.o_ready), 32'(tbl[i].rdy));
      @(posedge i_clk);
      #1;
      chk($sformatf("row%0d_valid", i), 32'(bus.o_valid), 32'(tbl[i].ev));
      chk($sformatf("row%0d_data", i), bus.o_data, tbl[i].ed);
      chk($sformatf("row%0d_retired", i), ret_cnt, PERF ? 32'(tbl[i].r) : 32'h0);
      chk($sformatf("row%0d_stall", i), stall_cnt, PERF ? 32'(tbl[i].s) : 32'h0);
      chk($sformatf("row%0d_bubble", i), bub_cnt, PERF ? 32'(tbl[i].b) : 32'h0);
    end

    // Refill the pipe; bb, dd and ee drain out on the way (stage1 was a bubble).
    drive(1'b1, 8'hf1, 4'b0000, 4'b0000, 1'b1, 1'b0);
    sb_q.push_back(8'hbb);
    @(posedge i_clk); #1;
    drive(1'b1, 8'hf2, 4'b0000, 4'b0000, 1'b1, 1'b0);
    sb_q.push_back(8'hdd);
    @(posedge i_clk); #1;
    drive(1'b1, 8'hf3, 4'b0000, 4'b0000, 1'b1, 1'b0);
    @(posedge i_clk); #1;
    drive(1'b1, 8'hf4, 4'b0000, 4'b0000, 1'b1, 1'b0);
    sb_q.push_back(8'hee);
    @(posedge i_clk); #1;
    chk("refill_valid", 32'(bus.o_valid), 32'hf);
    chk("refill_data", bus.o_data, 32'hf1f2f3f4);
    chk("refill_retired", ret_cnt, PERF ? 32'd9 : 32'h0);

    // Asynchronous reset between edges clears everything immediately.
    drive(1'b0, 8'h00, 4'b0000, 4'b0000, 1'b1, 1'b0);
    #2;
    i_reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.o_valid), 32'h0);
    chk("async_rst_data", bus.o_data, 32'h0);
    chk("async_rst_retired", ret_cnt, 32'h0);
    chk("async_rst_stall", stall_cnt, 32'h0);
    chk("async_rst_bubble", bub_cnt, 32'h0);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
